pipe_skid: RTL and testbench
============================

PIPE_SKID -- requirements
Module: pipe_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-low, sampled on the clk rising edge.
REQ-004 SHALL have port flush, input, 1, synchronous pipeline flush (branch redirect/exception).
REQ-005 SHALL have port pin_valid, input, 1, upstream beat valid.
REQ-006 SHALL have port pin_data, input, DATA_WIDTH, upstream payload.
REQ-007 SHALL have port pin_ready, output, 1, registered acceptance signal to upstream.
REQ-008 SHALL have port pout_valid, output, 1, downstream beat valid.
REQ-009 SHALL have port pout_data, output, DATA_WIDTH, downstream payload.
REQ-010 SHALL have port pout_ready, input, 1, downstream acceptance.

Function
REQ-011 SHALL decouple both directions: pin_ready, pout_valid and pout_data driven only from flops, with no combinational path from pout_ready to pin_ready.
REQ-012 SHALL hold a main register and a one-entry skid register; states are EMPTY (none valid), BUSY (main valid) and FULL (main and skid valid).
REQ-013 SHALL define beat transfer as a valid&ready pair on the same edge; in_fire = pin_valid&pin_ready and out_fire = pout_valid&pout_ready.
REQ-014 SHALL transition EMPTY->BUSY on in_fire, loading main with pin_data.
REQ-015 SHALL, in BUSY: in_fire&out_fire -> stay BUSY, main<=pin_data; in_fire only -> FULL, skid<=pin_data; out_fire only -> EMPTY; neither -> hold.
REQ-016 SHALL, in FULL: keep pin_ready=0; out_fire -> BUSY with main<=skid; otherwise hold.
REQ-017 SHALL drive pin_ready=1 in EMPTY and BUSY, and 0 in FULL, all as a registered next-state value.
REQ-018 SHALL drive pout_valid=1 in BUSY/FULL, with pout_data=main; pout_data SHALL be all-zero whenever pout_valid=0.
REQ-019 SHALL keep pout_valid and pout_data stable while pout_valid=1 and pout_ready=0.
REQ-020 SHALL deliver beats in order with no loss or duplication; latency is 1 cycle from in_fire to pout_valid, and sustained throughput is 1 beat/cycle when pout_ready stays high.
REQ-021 SHALL, on flush=1, go to EMPTY next cycle with pin_ready=1; beats in main/skid and any beat firing that cycle SHALL be discarded.
REQ-022 SHALL give priority reset > flush > normal transitions.

Reset
REQ-023 SHALL, while rst=0 at an edge, enter EMPTY: pout_valid=0, pout_data=0, pin_ready=1 from the next cycle; any in-flight beats SHALL be dropped.
REQ-024 SHALL not require reset of the payload registers, since their values are masked by REQ-018.

Configuration
REQ-025 SHALL compile in, when macro YSYX_23060251_PIPE_PERF_EN is defined, two 32-bit wrap-around counters: output ports perf_stall_cnt (cycles with pout_valid&~pout_ready) and perf_full_cnt (cycles in FULL), both cleared by reset and not by flush.
REQ-026 SHALL, without YSYX_23060251_PIPE_PERF_EN, omit those ports and counters, with all other behaviour identical.

Structure
REQ-027 SHALL place the state enum typedef (EMPTY/BUSY/FULL, 2-bit) and the perf counter width constant in shared package ysyx_23060251_pipe_pkg.
REQ-028 SHALL place the counters in sub-module pipe_skid_perf, instantiated only under YSYX_23060251_PIPE_PERF_EN.

Verification
REQ-029 SHALL cover streaming: pout_ready=1, beats 0x11,0x22,0x33 on consecutive cycles -> appear on pout_data on cycles 1,2,3 with no bubbles.
REQ-030 SHALL cover backpressure: pout_ready=0, send 0xA then 0xB -> FULL, pin_ready=0 next cycle; pout_ready=1 -> 0xA then 0xB out, pin_ready=1 after 0xA leaves.
REQ-031 SHALL cover the registered ready path: pout_ready toggled every cycle under random pin_valid -> pin_ready never changes in the same cycle as pout_ready; scoreboard shows no loss or duplication.
REQ-032 SHALL cover flush in FULL with pin_valid=1 (0xC) -> next cycle pout_valid=0, pout_data=0, pin_ready=1; 0xC never emitted.
REQ-033 SHALL cover mid-stream reset: rst=0 for one cycle while BUSY -> EMPTY next cycle, and with YSYX_23060251_PIPE_PERF_EN both counters read 0.
REQ-034 SHALL cover counters under YSYX_23060251_PIPE_PERF_EN: hold pout_ready=0 for 5 cycles with 2 beats queued -> perf_stall_cnt=5 and perf_full_cnt=4.

Source files
------------

// File: rtl/ysyx_23060251_pipe_pkg.sv
// Purpose   : shared types and constants for the pipe_skid slice.
// Latency   : n/a (declarations only).
// Backpress.: n/a.
// Contents  : pipe_state_e (EMPTY/BUSY/FULL), PERF_CNT_W, occupancy helpers.
package ysyx_23060251_pipe_pkg;

    // Occupancy of the main/skid pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,   // neither register holds a beat
        ST_BUSY  = 2'b01,   // main holds a beat
        ST_FULL  = 2'b10    // main and skid both hold a beat
    } pipe_state_e;

    // Width of the optional performance counters.
    localparam int unsigned PERF_CNT_W = 32;

    // Upstream may push whenever the skid slot is free.
    function automatic logic state_has_room(input pipe_state_e s);
        return (s != ST_FULL);
    endfunction

    // Downstream sees a beat whenever main is occupied.
    function automatic logic state_has_data(input pipe_state_e s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_skid_perf.sv
// Purpose   : stall / full-occupancy event counters for pipe_skid.
// Latency   : counters reflect an event one cycle after it is presented.
// Backpress.: none; pure observer, never stalls the pipe.
// Macro     : YSYX_23060251_PIPE_PERF_EN (module exists only when defined).
// Ports     : clk, rst (sync active-low), i_stall, i_full -> o_stall_cnt, o_full_cnt.
`ifdef YSYX_23060251_PIPE_PERF_EN
module pipe_skid_perf
    import ysyx_23060251_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_full,
    output logic [PERF_CNT_W-1:0] o_stall_cnt,
    output logic [PERF_CNT_W-1:0] o_full_cnt
);

    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_full_cnt;

    // Counters wrap naturally; only reset clears them (flush does not).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_full_cnt  <= '0;
        end else begin
            if (i_stall) begin
                r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
            end
            if (i_full) begin
                r_full_cnt <= r_full_cnt + PERF_CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_full_cnt  = r_full_cnt;

endmodule
`endif

// File: rtl/pipe_skid.sv
// Purpose   : fully registered valid/ready pipeline stage with a one-entry skid buffer.
// Latency   : 1 cycle from in_fire to pout_valid; 1 beat/cycle sustained.
// Backpress.: pin_ready is a flop (low only when main+skid are full); no comb path from pout_ready.
// Ports     : clk, rst (sync active-low), flush, pin_valid/pin_data/pin_ready (upstream),
//             pout_valid/pout_data/pout_ready (downstream); with YSYX_23060251_PIPE_PERF_EN
//             also perf_stall_cnt / perf_full_cnt.
module pipe_skid
    import ysyx_23060251_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  pin_valid,
    input  logic [DATA_WIDTH-1:0] pin_data,
    output logic                  pin_ready,
    output logic                  pout_valid,
    output logic [DATA_WIDTH-1:0] pout_data,
    input  logic                  pout_ready
`ifdef YSYX_23060251_PIPE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_full_cnt
`endif
);

    pipe_state_e           r_state;
    pipe_state_e           w_state_nxt;
    logic                  r_pin_ready;
    logic                  r_pout_valid;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid;
    logic                  w_pin_ready_nxt;
    logic                  w_pout_valid_nxt;

    // Handshakes are evaluated against the registered outputs, which is
    // what the neighbours actually observe.
    assign w_in_fire  = pin_valid    & r_pin_ready;
    assign w_out_fire = r_pout_valid & pout_ready;

    // ------------------------------------------------------------------
    // State register. Ready/valid are registered copies of the next-state
    // decode so that both outputs come straight from flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_EMPTY;
            r_pin_ready  <= 1'b1;
            r_pout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pin_ready  <= w_pin_ready_nxt;
            r_pout_valid <= w_pout_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Flush overrides every normal transition; reset is
    // applied above it in the state register.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_state_nxt = ST_FULL;
                    end else if (!w_in_fire && w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath-enable logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_pin_ready_nxt  = state_has_room(w_state_nxt);
        w_pout_valid_nxt = state_has_data(w_state_nxt);
        if (!flush) begin
            case (r_state)
                ST_EMPTY: begin
                    w_load_main_in = w_in_fire;
                end
                ST_BUSY: begin
                    // Simultaneous in/out replaces main in place; an
                    // unmatched push parks the new beat in skid.
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                    end
                end
                ST_FULL: begin
                    w_load_main_skid = w_out_fire;
                end
                default: begin
                    w_load_main_in = 1'b0;
                end
            endcase
        end
    end

    // Payload registers carry no reset; their contents are masked on the
    // output whenever pout_valid is low.
    always_ff @(posedge clk) begin
        if (w_load_main_in) begin
            r_main <= pin_data;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end
        if (w_load_skid) begin
            r_skid <= pin_data;
        end
    end

    assign pin_ready  = r_pin_ready;
    assign pout_valid = r_pout_valid;
    assign pout_data  = r_main & {DATA_WIDTH{r_pout_valid}};

`ifdef YSYX_23060251_PIPE_PERF_EN
    pipe_skid_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (r_pout_valid & ~pout_ready),
        .i_full      (r_state == ST_FULL),
        .o_stall_cnt (perf_stall_cnt),
        .o_full_cnt  (perf_full_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Purpose   : self-checking bench for pipe_skid (queue model + directed literals).
// Latency   : n/a.
// Backpress.: exercises pout_ready held low, toggling and streaming.
module tb_pipe_skid;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          pin_valid;
    logic [DW-1:0] pin_data;
    logic          pin_ready;
    logic          pout_valid;
    logic [DW-1:0] pout_data;
    logic          pout_ready;
`ifdef YSYX_23060251_PIPE_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_full_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .pin_valid  (pin_valid),
        .pin_data   (pin_data),
        .pin_ready  (pin_ready),
        .pout_valid (pout_valid),
        .pout_data  (pout_data),
        .pout_ready (pout_ready)
`ifdef YSYX_23060251_PIPE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the stage is a FIFO of depth two. Head is what downstream
    // sees, room exists while fewer than two beats are held.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] acc_log[$];
    logic [DW-1:0] out_log[$];
    bit            log_en  = 1'b0;
    logic          prev_dv = 1'b0;
    logic [DW-1:0] prev_dd = '0;

    always @(posedge clk) begin
        bit in_f;
        bit out_f;
        in_f  = pin_valid  && (m_q.size() < 2);
        out_f = pout_ready && (m_q.size() > 0);
        if (log_en && in_f)               acc_log.push_back(pin_data);
        if (log_en && prev_dv && pout_ready) out_log.push_back(prev_dd);
        if (!rst || flush) begin
            m_q.delete();
        end else begin
            if (out_f) void'(m_q.pop_front());
            if (in_f)  m_q.push_back(pin_data);
        end
        #1;
        chk("m_pout_valid", {31'd0, pout_valid}, {31'd0, m_q.size() > 0});
        chk("m_pout_data",  pout_data, (m_q.size() > 0) ? m_q[0] : 32'd0);
        chk("m_pin_ready",  {31'd0, pin_ready}, {31'd0, m_q.size() < 2});
        prev_dv = pout_valid;
        prev_dd = pout_data;
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; pin_valid = 1'b0; pin_data = '0; pout_ready = 1'b0;
        nxt(); nxt();
        chk("rst_pout_valid", {31'd0, pout_valid}, 32'd0);
        chk("rst_pout_data",  pout_data, 32'd0);
        chk("rst_pin_ready",  {31'd0, pin_ready}, 32'd1);
        rst = 1'b1;

        // Streaming, no bubbles.
        pout_ready = 1'b1; pin_valid = 1'b1; pin_data = 32'h11;
        nxt(); chk("stream_v1", {31'd0, pout_valid}, 32'd1); chk("stream_d1", pout_data, 32'h11);
        pin_data = 32'h22;
        nxt(); chk("stream_d2", pout_data, 32'h22);
        pin_data = 32'h33;
        nxt(); chk("stream_d3", pout_data, 32'h33);
        pin_valid = 1'b0;
        nxt(); chk("stream_end_v", {31'd0, pout_valid}, 32'd0); chk("stream_end_d", pout_data, 32'd0);

        // Backpressure into FULL, then drain.
        pout_ready = 1'b0; pin_valid = 1'b1; pin_data = 32'hA;
        nxt(); chk("bp_d_a", pout_data, 32'hA); chk("bp_rdy_busy", {31'd0, pin_ready}, 32'd1);
        pin_data = 32'hB;
        nxt(); chk("bp_rdy_full", {31'd0, pin_ready}, 32'd0); chk("bp_hold_a", pout_data, 32'hA);
        pin_valid = 1'b0; pout_ready = 1'b1;
        nxt(); chk("bp_d_b", pout_data, 32'hB); chk("bp_rdy_after_a", {31'd0, pin_ready}, 32'd1);
        nxt(); chk("bp_empty", {31'd0, pout_valid}, 32'd0);

        // Flush while FULL with a beat offered.
        pout_ready = 1'b0; pin_valid = 1'b1; pin_data = 32'h1;
        nxt(); pin_data = 32'h2;
        nxt(); chk("fl_full_rdy", {31'd0, pin_ready}, 32'd0);
        pin_data = 32'hC; flush = 1'b1;
        nxt(); flush = 1'b0; pin_valid = 1'b0;
        chk("fl_v", {31'd0, pout_valid}, 32'd0); chk("fl_d", pout_data, 32'd0);
        chk("fl_rdy", {31'd0, pin_ready}, 32'd1);
        pout_ready = 1'b1;
        nxt(); nxt(); chk("fl_no_c", {31'd0, pout_valid}, 32'd0);

        // Flush while BUSY discards the beat firing that same cycle.
        pout_ready = 1'b0; pin_valid = 1'b1; pin_data = 32'hD;
        nxt(); pin_data = 32'hE; flush = 1'b1;
        nxt(); flush = 1'b0; pin_valid = 1'b0; pout_ready = 1'b1;
        chk("flb_v", {31'd0, pout_valid}, 32'd0);
        nxt(); chk("flb_no_e", {31'd0, pout_valid}, 32'd0);

        // Mid-stream reset while BUSY (stalled, so counters are live).
        pout_ready = 1'b0; pin_valid = 1'b1; pin_data = 32'h5;
        nxt(); chk("mr_busy", {31'd0, pout_valid}, 32'd1);
        pin_data = 32'h6; rst = 1'b0;
        nxt(); rst = 1'b1; pin_valid = 1'b0;
        chk("mr_v", {31'd0, pout_valid}, 32'd0); chk("mr_d", pout_data, 32'd0);
        chk("mr_rdy", {31'd0, pin_ready}, 32'd1);
`ifdef YSYX_23060251_PIPE_PERF_EN
        chk("mr_stall_cnt", perf_stall_cnt, 32'd0);
        chk("mr_full_cnt",  perf_full_cnt,  32'd0);
`endif

        // Two beats queued, pout_ready low for five cycles.
        pout_ready = 1'b0; pin_valid = 1'b1; pin_data = 32'h1;
        nxt(); pin_data = 32'h2;
        nxt(); pin_valid = 1'b0;
        nxt(); nxt(); nxt(); nxt();
`ifdef YSYX_23060251_PIPE_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd5);
        chk("perf_full_cnt",  perf_full_cnt,  32'd4);
`endif
        chk("perf_hold_d", pout_data, 32'h1);
        pout_ready = 1'b1;
        nxt(); nxt(); nxt();

        // Random pin_valid with pout_ready toggling every cycle.
        acc_log.delete(); out_log.delete(); log_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            nxt();
            pin_valid  = 1'($urandom_range(0, 1));
            pin_data   = $urandom;
            pout_ready = ~pout_ready;
            #1;
            chk("reg_ready", {31'd0, pin_ready}, {31'd0, m_q.size() < 2});
        end
        nxt(); pin_valid = 1'b0; pout_ready = 1'b1;
        nxt(); nxt(); nxt(); nxt();
        log_en = 1'b0;
        chk("sb_count", out_log.size(), acc_log.size());
        for (int i = 0; i < acc_log.size() && i < out_log.size(); i++) begin
            chk("sb_beat", out_log[i], acc_log[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
